// File: rtl/i2s_pkg.sv
// Shared I2S definitions.
// Holds the framing-mode constants and the parameter legality check used by
// the transmitter (and later by the matching receiver).
package i2s_pkg;

  localparam int MODE_I2S = 0;  // data one SCLK after the LRCLK edge
  localparam int MODE_LJ  = 1;  // data aligned with the LRCLK edge

  // True when a parameter set describes a realisable serial format.
  function automatic bit params_ok(input int sample_bits, input int slot_bits,
                                   input int sclk_half, input int mclk_half);
    return (sample_bits >= 8) && (sample_bits <= 32) &&
           (slot_bits >= sample_bits) &&
           (sclk_half >= 1) && (mclk_half >= 1);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// SCLK / MCLK divider for the I2S transmitter.
// Ports:
//   clk  - system clock (sole clock)
//   rst  - synchronous active-high reset
//   sclk - registered serial bit clock, half period SCLK_HALF clk cycles
//   mclk - registered master clock, half period MCLK_HALF clk cycles
//   fall - strobe high in the clk cycle whose edge takes sclk from 1 to 0
module i2s_clk_gen #(
  parameter int SCLK_HALF = 8,
  parameter int MCLK_HALF = 1
) (
  input  logic clk,
  input  logic rst,
  output logic sclk,
  output logic mclk,
  output logic fall
);

  localparam int SW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam logic [SW-1:0] SCLK_LAST = SW'(SCLK_HALF - 1);
  localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_HALF - 1);

  logic [SW-1:0] sclk_cnt;
  logic [MW-1:0] mclk_cnt;
  logic          sclk_wrap;
  logic          mclk_wrap;

  assign sclk_wrap = (sclk_cnt == SCLK_LAST);
  assign mclk_wrap = (mclk_cnt == MCLK_LAST);
  // sclk is about to toggle while high: this edge is the falling one.
  assign fall      = sclk_wrap & sclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_cnt <= '0;
      mclk_cnt <= '0;
      sclk     <= 1'b0;
      mclk     <= 1'b0;
    end else begin
      sclk_cnt <= sclk_wrap ? '0 : sclk_cnt + SW'(1);
      mclk_cnt <= mclk_wrap ? '0 : mclk_cnt + MW'(1);
      if (sclk_wrap) sclk <= ~sclk;
      if (mclk_wrap) mclk <= ~mclk;
    end
  end

endmodule

// File: rtl/i2s_tx_stream.sv
// Stereo I2S / left-justified serial transmitter.
// Accepts sample pairs over valid/ready into a one-entry holding buffer and
// shifts them MSB-first onto SDIN, framed by LRCLK. All serial clocks are
// registered outputs derived from i_Clk.
// Ports:
//   i_Clk, i_Reset           - system clock, synchronous active-high reset
//   i_Sample_Valid, i_Left,
//   i_Right, o_Sample_Ready  - sample pair handshake
//   o_MCLK, o_SCLK, o_LRCLK,
//   o_SDIN                   - DAC interface
//   o_Frame_Start            - one-cycle pulse per frame load
//   o_Underrun               - one-cycle pulse when a frame loads unfed
module i2s_tx_stream
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS     = 16,
  parameter int SLOT_BITS       = 16,
  parameter int SCLK_HALF       = 8,
  parameter int MCLK_HALF       = 1,
  parameter int MODE            = 0,
  parameter int UNDERRUN_REPEAT = 0
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Sample_Valid,
  input  logic [SAMPLE_BITS-1:0] i_Left,
  input  logic [SAMPLE_BITS-1:0] i_Right,
  output logic                   o_Sample_Ready,
  output logic                   o_MCLK,
  output logic                   o_SCLK,
  output logic                   o_LRCLK,
  output logic                   o_SDIN,
  output logic                   o_Frame_Start,
  output logic                   o_Underrun
);

  if (!params_ok(SAMPLE_BITS, SLOT_BITS, SCLK_HALF, MCLK_HALF)) begin : g_bad_params
    $error("i2s_tx_stream: illegal parameter set");
  end

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] B_LAST  = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] B_RIGHT = BW'(SLOT_BITS);
  localparam logic [BW-1:0] B_DATA  = BW'(SAMPLE_BITS);

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;

  logic          fall;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_nxt;
  logic          load;
  logic          accept;
  logic          full;
  sample_t       hold_l, hold_r;
  sample_t       frame_l, frame_r;
  sample_t       load_l, load_r;
  logic          lj_bit;
  logic          lj_dly;

  // Left-justified stream bit at frame position b: sample MSB first, zero pad.
  function automatic logic stream_bit(input logic [BW-1:0] b,
                                      input sample_t l, input sample_t r);
    logic [BW-1:0] pos;
    sample_t       s;
    if (b >= B_RIGHT) begin
      pos = b - B_RIGHT;
      s   = r;
    end else begin
      pos = b;
      s   = l;
    end
    if (pos >= B_DATA) return 1'b0;
    s = s << pos;
    return s[SAMPLE_BITS-1];
  endfunction

  i2s_clk_gen #(
    .SCLK_HALF(SCLK_HALF),
    .MCLK_HALF(MCLK_HALF)
  ) u_clk_gen (
    .clk (i_Clk),
    .rst (i_Reset),
    .sclk(o_SCLK),
    .mclk(o_MCLK),
    .fall(fall)
  );

  assign bit_nxt        = (bit_cnt == B_LAST) ? '0 : bit_cnt + BW'(1);
  assign load           = fall && (bit_nxt == '0);
  assign accept         = i_Sample_Valid && !full;
  assign o_Sample_Ready = !full;

  // Frame contents that take effect at this fall event; an empty buffer at
  // load time is an underrun even if a pair is being accepted right now.
  always_comb begin
    load_l = frame_l;
    load_r = frame_r;
    if (load) begin
      if (full) begin
        load_l = hold_l;
        load_r = hold_r;
      end else if (UNDERRUN_REPEAT == 0) begin
        load_l = '0;
        load_r = '0;
      end
    end
  end

  assign lj_bit = stream_bit(bit_nxt, load_l, load_r);

  // Frame sequencing and serial outputs, updated on fall events
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      full          <= 1'b0;
      frame_l       <= '0;
      frame_r       <= '0;
      bit_cnt       <= B_LAST;
      lj_dly        <= 1'b0;
      o_LRCLK       <= 1'b0;
      o_SDIN        <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Underrun    <= 1'b0;
    end else begin
      o_Frame_Start <= load;
      o_Underrun    <= load && !full;
      if (fall) begin
        bit_cnt <= bit_nxt;
        frame_l <= load_l;
        frame_r <= load_r;
        o_LRCLK <= (bit_nxt >= B_RIGHT);
        lj_dly  <= lj_bit;
        o_SDIN  <= (MODE == MODE_LJ) ? lj_bit : lj_dly;
      end
      if (load && full) full <= 1'b0;
      else if (accept)  full <= 1'b1;
    end
  end

  // Holding buffer data
  always_ff @(posedge i_Clk) begin
    if (accept) begin
      hold_l <= i_Left;
      hold_r <= i_Right;
    end
  end

endmodule

// File: tb/tb_i2s_tx_stream.sv
module tb_i2s_tx_stream;

  // Instance 0: 16/16 LJ, 1: 16/16 I2S (shares inputs with 0), 2: 24/32 LJ repeat
  localparam int P_SB[3] = '{16, 16, 24};
  localparam int P_SL[3] = '{16, 16, 32};
  localparam int P_SH[3] = '{2, 2, 1};
  localparam int P_MH[3] = '{1, 1, 2};
  localparam int P_MD[3] = '{1, 0, 1};
  localparam int P_UR[3] = '{0, 0, 1};

  logic        clk, rst;
  logic        v0, v2;
  logic [15:0] l0, r0;
  logic [23:0] l2, r2;
  logic rdy[3], mclk[3], sclk[3], lr[3], sd[3], fs[3], ur[3];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // reference model state
  int          t[3];
  logic        mfull[3];
  logic [31:0] mbl[3], mbr[3], mfl[3], mfr[3];
  logic        ljp[3];
  logic e_sclk[3], e_mclk[3], e_lr[3], e_sd[3], e_fs[3], e_ur[3], e_rdy[3];

  i2s_tx_stream #(.SAMPLE_BITS(16), .SLOT_BITS(16), .SCLK_HALF(2), .MCLK_HALF(1),
                  .MODE(1), .UNDERRUN_REPEAT(0)) u0 (
    .i_Clk(clk), .i_Reset(rst), .i_Sample_Valid(v0), .i_Left(l0), .i_Right(r0),
    .o_Sample_Ready(rdy[0]), .o_MCLK(mclk[0]), .o_SCLK(sclk[0]), .o_LRCLK(lr[0]),
    .o_SDIN(sd[0]), .o_Frame_Start(fs[0]), .o_Underrun(ur[0]));

  i2s_tx_stream #(.SAMPLE_BITS(16), .SLOT_BITS(16), .SCLK_HALF(2), .MCLK_HALF(1),
                  .MODE(0), .UNDERRUN_REPEAT(0)) u1 (
    .i_Clk(clk), .i_Reset(rst), .i_Sample_Valid(v0), .i_Left(l0), .i_Right(r0),
    .o_Sample_Ready(rdy[1]), .o_MCLK(mclk[1]), .o_SCLK(sclk[1]), .o_LRCLK(lr[1]),
    .o_SDIN(sd[1]), .o_Frame_Start(fs[1]), .o_Underrun(ur[1]));

  i2s_tx_stream #(.SAMPLE_BITS(24), .SLOT_BITS(32), .SCLK_HALF(1), .MCLK_HALF(2),
                  .MODE(1), .UNDERRUN_REPEAT(1)) u2 (
    .i_Clk(clk), .i_Reset(rst), .i_Sample_Valid(v2), .i_Left(l2), .i_Right(r2),
    .o_Sample_Ready(rdy[2]), .o_MCLK(mclk[2]), .o_SCLK(sclk[2]), .o_LRCLK(lr[2]),
    .o_SDIN(sd[2]), .o_Frame_Start(fs[2]), .o_Underrun(ur[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout at %0t", nm, $time);
  endtask

  // Stream bit at frame position b, straight from the format definition.
  function automatic logic ref_bit(input logic [31:0] l, input logic [31:0] r,
                                   input int b, input int sb, input int sl);
    int          p;
    logic [31:0] s;
    logic [31:0] tmp;
    p = b % sl;
    s = (b >= sl) ? r : l;
    if (p >= sb) return 1'b0;
    tmp = s >> (sb - 1 - p);
    return tmp[0];
  endfunction

  // Model advances by one i_Clk edge; timing derived from elapsed cycles.
  task automatic model_step(input int i);
    logic        v, acc, bt;
    logic [31:0] il, ir;
    int          m, b;
    if (i == 2) begin v = v2; il = 32'(l2); ir = 32'(r2); end
    else        begin v = v0; il = 32'(l0); ir = 32'(r0); end
    if (rst) begin
      t[i] = 0; mfull[i] = 1'b0; mfl[i] = '0; mfr[i] = '0; ljp[i] = 1'b0;
      e_sclk[i] = 1'b0; e_mclk[i] = 1'b0; e_lr[i] = 1'b0; e_sd[i] = 1'b0;
      e_fs[i] = 1'b0; e_ur[i] = 1'b0; e_rdy[i] = 1'b1;
      return;
    end
    acc  = v && !mfull[i];
    t[i] = t[i] + 1;
    e_sclk[i] = ((t[i] / P_SH[i]) % 2) == 1;
    e_mclk[i] = ((t[i] / P_MH[i]) % 2) == 1;
    e_fs[i] = 1'b0;
    e_ur[i] = 1'b0;
    if (t[i] % (2 * P_SH[i]) == 0) begin
      m = t[i] / (2 * P_SH[i]);
      b = (m - 1) % (2 * P_SL[i]);
      if (b == 0) begin
        e_fs[i] = 1'b1;
        if (mfull[i]) begin
          mfl[i] = mbl[i]; mfr[i] = mbr[i]; mfull[i] = 1'b0;
        end else begin
          e_ur[i] = 1'b1;
          if (P_UR[i] == 0) begin mfl[i] = '0; mfr[i] = '0; end
        end
      end
      bt = ref_bit(mfl[i], mfr[i], b, P_SB[i], P_SL[i]);
      e_lr[i] = (b >= P_SL[i]);
      e_sd[i] = (P_MD[i] == 1) ? bt : ljp[i];
      ljp[i]  = bt;
    end
    if (acc) begin mfull[i] = 1'b1; mbl[i] = il; mbr[i] = ir; end
    e_rdy[i] = !mfull[i];
  endtask

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d.sclk", i),  64'(sclk[i]), 64'(e_sclk[i]));
        chk($sformatf("u%0d.mclk", i),  64'(mclk[i]), 64'(e_mclk[i]));
        chk($sformatf("u%0d.lrclk", i), 64'(lr[i]),   64'(e_lr[i]));
        chk($sformatf("u%0d.sdin", i),  64'(sd[i]),   64'(e_sd[i]));
        chk($sformatf("u%0d.fstart", i), 64'(fs[i]),  64'(e_fs[i]));
        chk($sformatf("u%0d.underrun", i), 64'(ur[i]), 64'(e_ur[i]));
        chk($sformatf("u%0d.ready", i), 64'(rdy[i]),  64'(e_rdy[i]));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.u%0d.outs", tag, i),
          {58'd0, sclk[i], mclk[i], lr[i], sd[i], fs[i], ur[i]}, 64'd0);
      chk($sformatf("%s.u%0d.ready", tag, i), 64'(rdy[i]), 64'd1);
    end
  endtask

  task automatic wait_fs(input int i, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (fs[i]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail_to($sformatf("u%0d.wait_frame", i));
  endtask

  task automatic next_rise(input int i, output bit ok);
    logic prev;
    prev = sclk[i];
    ok   = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (sclk[i] && !prev) begin ok = 1'b1; break; end
      prev = sclk[i];
    end
    if (!ok) fail_to($sformatf("u%0d.sclk_rise", i));
  endtask

  // Called just after a negedge; returns at the negedge after the accept.
  task automatic send0(input logic [15:0] l, input logic [15:0] r);
    v0 = 1'b1; l0 = l; r0 = r;
    for (int n = 0; n < 400 && !rdy[0]; n++) @(negedge clk);
    if (!rdy[0]) fail_to("u0.ready");
    @(negedge clk);
    v0 = 1'b0;
  endtask

  task automatic send2(input logic [23:0] l, input logic [23:0] r);
    v2 = 1'b1; l2 = l; r2 = r;
    for (int n = 0; n < 400 && !rdy[2]; n++) @(negedge clk);
    if (!rdy[2]) fail_to("u2.ready");
    @(negedge clk);
    v2 = 1'b0;
  endtask

  task automatic capture_u2(input string tag);
    bit          ok;
    logic [63:0] w, lw;
    w = '0; lw = '0;
    for (int k = 0; k < 64; k++) begin
      next_rise(2, ok);
      w  = {w[62:0], sd[2]};
      lw = {lw[62:0], lr[2]};
    end
    chk({tag, ".data"}, w, 64'h80000100_5A5A5A00);
    chk({tag, ".lrclk"}, lw, 64'h00000000_FFFFFFFF);
  endtask

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vt[4];
    bit          ok;
    logic [31:0] w0, w1, lw;
    int          n_ur, n_fs, n_one, n_acc;
    bit          took;

    vt[0] = '{16'hA5F0, 16'h0F0F, 32'hA5F00F0F};
    vt[1] = '{16'h8000, 16'h0001, 32'h80000001};
    vt[2] = '{16'hFFFF, 16'h0000, 32'hFFFF0000};
    vt[3] = '{16'h1234, 16'hEDCB, 32'h1234EDCB};

    rst = 1'b1; v0 = 1'b0; v2 = 1'b0; l0 = '0; r0 = '0; l2 = '0; r2 = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    chk_en = 1'b1;
    rst = 1'b0;

    // random traffic, model checks every cycle
    repeat (3000) begin
      @(negedge clk);
      v0 = ($urandom_range(0, 2) == 0);
      l0 = 16'($urandom); r0 = 16'($urandom);
      v2 = ($urandom_range(0, 3) == 0);
      l2 = 24'($urandom); r2 = 24'($urandom);
    end
    v0 = 1'b0; v2 = 1'b0;
    @(negedge clk);

    // vector table: u0 (LJ) and u1 (I2S) carry the same pair
    for (int vi = 0; vi < 4; vi++) begin
      send0(vt[vi].l, vt[vi].r);
      @(negedge clk);
      wait_fs(0, ok);
      w0 = '0; w1 = '0; lw = '0;
      for (int k = 0; k < 33; k++) begin
        next_rise(0, ok);
        if (k < 32) begin w0 = {w0[30:0], sd[0]}; lw = {lw[30:0], lr[0]}; end
        if (k > 0) w1 = {w1[30:0], sd[1]};
      end
      chk($sformatf("vec%0d.lj", vi), 64'(w0), 64'(vt[vi].exp));
      chk($sformatf("vec%0d.i2s", vi), 64'(w1), 64'(vt[vi].exp));
      chk($sformatf("vec%0d.lrclk", vi), 64'(lw), 64'h0000FFFF);
    end

    // two starved frames on u0: zeros, one underrun pulse per frame
    wait_fs(0, ok);
    n_ur = 0; n_fs = 0; n_one = 0;
    for (int k = 0; k < 256; k++) begin
      if (k > 0) @(negedge clk);
      n_ur  += int'(ur[0]);
      n_fs  += int'(fs[0]);
      n_one += int'(sd[0]);
    end
    chk("starve.underruns", 64'(n_ur), 64'd2);
    chk("starve.frames", 64'(n_fs), 64'd2);
    chk("starve.sdin_ones", 64'(n_one), 64'd0);

    // u2: 24-bit samples in 32-bit slots, then a repeated frame on underrun
    send2(24'h800001, 24'h5A5A5A);
    @(negedge clk);
    wait_fs(2, ok);
    chk("u2.first.underrun", 64'(ur[2]), 64'd0);
    capture_u2("u2.first");
    wait_fs(2, ok);
    chk("u2.repeat.underrun", 64'(ur[2]), 64'd1);
    capture_u2("u2.repeat");

    // valid held high: one accept per frame
    wait_fs(0, ok);
    v0 = 1'b1; l0 = 16'h0101; r0 = 16'h0202;
    took = 1'b0;
    for (int f = 0; f < 3; f++) begin
      n_acc = 0;
      for (int k = 0; k < 128; k++) begin
        if (k > 0 || f > 0) @(negedge clk);
        if (f == 0 && k == 1) chk("hold.ready_drop", 64'(rdy[0]), 64'd0);
        if (took) begin l0 = l0 + 16'h1111; r0 = r0 - 16'h0303; took = 1'b0; end
        if (rdy[0]) begin n_acc++; took = 1'b1; end
      end
      chk($sformatf("hold.accepts_f%0d", f), 64'(n_acc), 64'd1);
    end
    v0 = 1'b0;

    // reset in the middle of a right slot
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (lr[0]) begin ok = 1'b1; break; end
    end
    if (!ok) fail_to("u0.right_slot");
    rst = 1'b1; v0 = 1'b1; l0 = 16'hC001; r0 = 16'h0003;
    @(negedge clk);
    check_reset_state("midreset");
    rst = 1'b0;
    @(negedge clk);
    v0 = 1'b0;
    wait_fs(0, ok);
    chk("midreset.first_msb", 64'(sd[0]), 64'd1);
    chk("midreset.first_lrclk", 64'(lr[0]), 64'd0);
    w0 = '0;
    for (int k = 0; k < 32; k++) begin
      next_rise(0, ok);
      w0 = {w0[30:0], sd[0]};
    end
    chk("midreset.frame", 64'(w0), 64'hC0010003);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx_stream.md
# i2s_tx_stream

Parametrised I2S/left-justified stereo transmitter: sits between the synthesizer's sample generator and the external audio DAC. Accepts stereo sample pairs through a valid/ready handshake into a one-entry holding buffer and serialises them MSB-first onto SDIN, framed by LRCLK. Generates MCLK, SCLK and LRCLK as registered outputs from the single system clock; no logic is clocked by a generated clock. Generalises the fixed 16-bit, fixed-divider transmitter to any sample width, slot width and divider, and adds a selectable framing mode, back-pressure and underrun detection.

## Interface
- SAMPLE_BITS, 16: bits per channel sample, 8..32.
- SLOT_BITS, 16: SCLK periods per channel slot, >= SAMPLE_BITS; padding bits are 0.
- SCLK_HALF, 8: i_Clk cycles per SCLK half-period, >= 1.
- MCLK_HALF, 1: i_Clk cycles per MCLK half-period, >= 1.
- MODE, 0: 0 = Philips I2S (data one SCLK after LRCLK edge), 1 = left-justified.
- UNDERRUN_REPEAT, 0: on underrun, 0 = send zeros, 1 = resend last pair.
- i_Clk  in  1  system clock; sole clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Sample_Valid  in  1  sample pair offered.
- i_Left  in  SAMPLE_BITS  left sample, two's complement.
- i_Right  in  SAMPLE_BITS  right sample, two's complement.
- o_Sample_Ready  out  1  holding buffer empty; pair accepted when valid && ready.
- o_MCLK  out  1  master clock.
- o_SCLK  out  1  serial bit clock.
- o_LRCLK  out  1  word select: 0 = left, 1 = right.
- o_SDIN  out  1  serial data.
- o_Frame_Start  out  1  one-cycle pulse when a frame is loaded.
- o_Underrun  out  1  one-cycle pulse when a frame loads with no buffered pair.

## Operation
- SCLK divider: counter 0..SCLK_HALF-1; o_SCLK toggles when it wraps. A "fall event" is the i_Clk cycle in which o_SCLK goes 1->0. o_SDIN and o_LRCLK change only on fall events, so the DAC samples on SCLK rising edges.
- MCLK divider: independent counter 0..MCLK_HALF-1; o_MCLK toggles on wrap.
- Bit counter b, 0..2*SLOT_BITS-1, advances by 1 on each fall event and wraps to 0. Slot position p = b mod SLOT_BITS. Channel = (b >= SLOT_BITS).
- Frame load on the fall event where b becomes 0:
  - If the holding buffer is full, its pair loads into the frame register and the buffer is cleared.
  - If the buffer is empty, the frame register loads zeros or the last pair (per UNDERRUN_REPEAT), and o_Underrun pulses.
  - o_Frame_Start pulses on every frame load.
- Left-justified stream: bit at b = sample[SAMPLE_BITS-1-p] of the current channel for p < SAMPLE_BITS, otherwise 0.
- o_LRCLK = channel of b, in both modes.
- MODE 1: o_SDIN = left-justified stream bit at b.
- MODE 0: o_SDIN = left-justified stream delayed by one fall event, so it carries the previous bit, including across the frame wrap. The MSB therefore follows the LRCLK edge by one SCLK.
- Handshake: o_Sample_Ready = ~full, combinational from the registered full flag.
  - If accept and frame load occur in the same cycle, the buffer was empty, so that frame underruns. The accepted pair stays buffered for the next frame.
  - An input pair is never dropped and never overwritten.

## Timing
- Reset (i_Reset high at a rising i_Clk edge) clears all of the following on that edge:
  - Outputs: o_MCLK, o_SCLK, o_LRCLK, o_SDIN, o_Frame_Start, o_Underrun = 0; o_Sample_Ready = 1.
  - Internal state: holding buffer empty, frame register 0, MODE 0 delay flop 0, both divider counters 0.
  - Bit counter set to 2*SLOT_BITS-1, so the first fall event starts frame 0.
- Reset mid-frame aborts the frame immediately; nothing resumes afterwards.
- First fall event after reset: at i_Clk edge 2*SCLK_HALF after reset release.
- Frame period: 2*SLOT_BITS*2*SCLK_HALF i_Clk cycles.
- Latency: a pair accepted before a frame load has its left MSB on o_SDIN at that fall event (MODE 1), or one SCLK later (MODE 0).
- Throughput: at most one pair per frame.

## Structure
- Shared package i2s_pkg holds:
  - MODE_I2S = 0 and MODE_LJ = 1 constants.
  - Parameter-legality assertions (SLOT_BITS >= SAMPLE_BITS, SCLK_HALF >= 1, MCLK_HALF >= 1), shared with a future i2s_rx.
- One sub-module: i2s_clk_gen, holding the SCLK and MCLK dividers and producing o_SCLK, o_MCLK and the fall-event strobe.

## Test plan
- SAMPLE_BITS=16, SLOT_BITS=16, SCLK_HALF=2, MODE 1; send L=16'hA5F0, R=16'h0F0F -> captured on SCLK rising edges: LRCLK=0 bits A5F0, then LRCLK=1 bits 0F0F; o_Frame_Start pulses once per 128 i_Clk cycles.
- Same stimulus, MODE 0 -> every bit is one SCLK later than in MODE 1. The left MSB (1) appears at b=1, and the right LSB (1) appears at b=0 of the next frame.
- SAMPLE_BITS=24, SLOT_BITS=32; L=24'h800001 -> 24 data bits, then 8 zero bits per slot.
- Hold i_Sample_Valid low for two frames:
  - UNDERRUN_REPEAT=0 -> o_Underrun pulses twice and SDIN stays 0.
  - UNDERRUN_REPEAT=1 -> the last pair repeats.
- Hold valid high continuously -> o_Sample_Ready drops after the first accept, and exactly one pair is accepted per frame.
- Assert i_Reset mid-right-slot -> all outputs are 0 on the next i_Clk edge, o_Sample_Ready is 1, and frame 0 restarts with left MSB at the first fall event.
